// File: rtl/vector_writeback_stage.sv
// ============================================================================
// Module   : vector_writeback_stage
// Purpose  : Final (WB) stage of the vector pipeline. Scalar results are
//            committed to the scalar RF one cycle after capture. Vector
//            results are written to the vector RF in LANES_PER_BEAT-wide
//            beats, and the upstream pipe is held while the burst drains.
// Options  : WB_FWD_EN - when defined, scalar commits are mirrored onto the
//            fwd_* bypass outputs; otherwise fwd_* are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_writeback_stage #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_LANES      = 16,
    parameter int LANES_PER_BEAT = 4,
    parameter int REG_ADDR_W     = 4,
    localparam int LANE_IDX_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic                             BlockPipe,
    input  logic                             RegWrite,
    input  logic                             MemtoReg,
    input  logic                             Vectorop,
    input  logic [REG_ADDR_W-1:0]            Rd,
    input  logic [DATA_WIDTH-1:0]            Alu_out,
    input  logic [DATA_WIDTH-1:0]            data_out,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]  VectorResult,
    output logic                             sreg_we,
    output logic [REG_ADDR_W-1:0]            sreg_waddr,
    output logic [DATA_WIDTH-1:0]            sreg_wdata,
    output logic                             vreg_we,
    output logic [REG_ADDR_W-1:0]            vreg_waddr,
    output logic [LANE_IDX_W-1:0]            vreg_lane_base,
    output logic [LANES_PER_BEAT*DATA_WIDTH-1:0] vreg_wdata,
    output logic                             stall_out,
    output logic                             fwd_valid,
    output logic [REG_ADDR_W-1:0]            fwd_rd,
    output logic [DATA_WIDTH-1:0]            fwd_data
);

    localparam int NUM_BEATS = NUM_LANES / LANES_PER_BEAT;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int BEAT_BITS = LANES_PER_BEAT * DATA_WIDTH;

    localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SCALAR = 2'd1;
    localparam logic [1:0] c_ST_VBURST = 2'd2;

    logic [1:0]                      state_q, state_d;
    logic [BEAT_W-1:0]               beat_q, beat_d;
    logic [REG_ADDR_W-1:0]           rd_q, rd_d;
    logic [DATA_WIDTH-1:0]           sdata_q, sdata_d;
    logic [NUM_LANES*DATA_WIDTH-1:0] vec_q, vec_d;

    logic                            w_in_scalar;
    logic                            w_in_burst;
    logic                            w_last_beat;
    logic                            w_accept;
    logic [BEAT_BITS-1:0]            w_beat_data;

    assign w_in_scalar = (state_q == c_ST_SCALAR);
    assign w_in_burst  = (state_q == c_ST_VBURST);
    assign w_last_beat = (beat_q == c_LAST_BEAT);

    // Upstream is held for every beat except the last, so the next
    // instruction can be taken on the edge that retires the final beat.
    assign stall_out = w_in_burst && !w_last_beat;
    assign w_accept  = in_valid && !BlockPipe && !stall_out;

    // Next-state: a fresh capture always wins; otherwise advance the burst or fall idle
    always_comb begin
        state_d = c_ST_IDLE;
        beat_d  = '0;
        rd_d    = rd_q;
        sdata_d = sdata_q;
        vec_d   = vec_q;
        if (w_accept && RegWrite) begin
            rd_d = Rd;
            if (Vectorop) begin
                // Vector R0 is an ordinary register and is always written
                state_d = c_ST_VBURST;
                vec_d   = VectorResult;
            end else if (Rd != '0) begin
                // Scalar R0 is hardwired zero, so such writes are dropped here
                state_d = c_ST_SCALAR;
                sdata_d = MemtoReg ? data_out : Alu_out;
            end
        end else if (w_in_burst && !w_last_beat) begin
            state_d = c_ST_VBURST;
            beat_d  = beat_q + BEAT_W'(1);
        end
    end

    // State and captured-operand registers; reset abandons any burst in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= c_ST_IDLE;
            beat_q  <= '0;
            rd_q    <= '0;
            sdata_q <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            rd_q    <= rd_d;
            sdata_q <= sdata_d;
            vec_q   <= vec_d;
        end
    end

    // Select the lane group addressed by the current beat
    always_comb begin
        w_beat_data = '0;
        for (int k = 0; k < NUM_BEATS; k++) begin
            if (beat_q == BEAT_W'(k)) begin
                w_beat_data = vec_q[k*BEAT_BITS +: BEAT_BITS];
            end
        end
    end

    // Write ports are gated so that they read all-zero whenever idle
    assign sreg_we        = w_in_scalar;
    assign sreg_waddr     = w_in_scalar ? rd_q : '0;
    assign sreg_wdata     = w_in_scalar ? sdata_q : '0;

    assign vreg_we        = w_in_burst;
    assign vreg_waddr     = w_in_burst ? rd_q : '0;
    assign vreg_lane_base = w_in_burst ?
                            (LANE_IDX_W'(beat_q) * LANE_IDX_W'(LANES_PER_BEAT)) : '0;
    assign vreg_wdata     = w_in_burst ? w_beat_data : '0;

`ifdef WB_FWD_EN
    // WB->EX bypass mirrors scalar commits only; vector beats never forward
    assign fwd_valid = sreg_we;
    assign fwd_rd    = sreg_waddr;
    assign fwd_data  = sreg_wdata;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vector_writeback_stage.sv
// ============================================================================
// Module   : tb_vector_writeback_stage
// Purpose  : Self-checking bench for vector_writeback_stage. A cycle-indexed
//            schedule of expected register-file writes is built from each
//            accepted instruction and compared against the DUT every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_writeback_stage;

    localparam int DW   = 16;
    localparam int NL   = 16;
    localparam int LPB  = 4;
    localparam int AW   = 4;
    localparam int NB   = NL / LPB;
    localparam int MAXC = 2048;

    logic              clk;
    logic              rst;
    logic              in_valid, BlockPipe, RegWrite, MemtoReg, Vectorop;
    logic [AW-1:0]     Rd;
    logic [DW-1:0]     Alu_out, data_out;
    logic [NL*DW-1:0]  VectorResult;
    logic              sreg_we, vreg_we, stall_out, fwd_valid;
    logic [AW-1:0]     sreg_waddr, vreg_waddr, fwd_rd;
    logic [DW-1:0]     sreg_wdata, fwd_data;
    logic [3:0]        vreg_lane_base;
    logic [LPB*DW-1:0] vreg_wdata;

    vector_writeback_stage #(
        .DATA_WIDTH(DW), .NUM_LANES(NL), .LANES_PER_BEAT(LPB), .REG_ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .BlockPipe(BlockPipe),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Vectorop(Vectorop), .Rd(Rd),
        .Alu_out(Alu_out), .data_out(data_out), .VectorResult(VectorResult),
        .sreg_we(sreg_we), .sreg_waddr(sreg_waddr), .sreg_wdata(sreg_wdata),
        .vreg_we(vreg_we), .vreg_waddr(vreg_waddr), .vreg_lane_base(vreg_lane_base),
        .vreg_wdata(vreg_wdata), .stall_out(stall_out),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    // Expected visible activity for one clock cycle
    typedef struct {
        bit          sw;
        bit [AW-1:0] sa;
        bit [DW-1:0] sd;
        bit          vw;
        bit [AW-1:0] va;
        bit [3:0]    vb;
        bit [63:0]   vd;
        bit          st;
    } exp_t;

    exp_t sched [MAXC];
    int   cyc;
    int   n_chk;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, act, expv);
        end
    endtask

    task automatic clear_sched(input int from);
        for (int c = from; c < MAXC; c++) begin
            sched[c] = '{default: 0};
        end
    endtask

    // Check this cycle's outputs, update the model from the sampled inputs, advance
    task automatic tick(output bit acc);
        exp_t e;
        @(negedge clk);
        e = sched[cyc];
        check_eq("sreg_we",    sreg_we,        e.sw);
        check_eq("sreg_waddr", sreg_waddr,     e.sa);
        check_eq("sreg_wdata", sreg_wdata,     e.sd);
        check_eq("vreg_we",    vreg_we,        e.vw);
        check_eq("vreg_waddr", vreg_waddr,     e.va);
        check_eq("lane_base",  vreg_lane_base, e.vb);
        check_eq("vreg_wdata", vreg_wdata,     e.vd);
        check_eq("stall_out",  stall_out,      e.st);
`ifdef WB_FWD_EN
        check_eq("fwd_valid",  fwd_valid,      e.sw);
        check_eq("fwd_rd",     fwd_rd,         e.sa);
        check_eq("fwd_data",   fwd_data,       e.sd);
`else
        check_eq("fwd_valid",  fwd_valid,      1'b0);
        check_eq("fwd_rd",     fwd_rd,         '0);
        check_eq("fwd_data",   fwd_data,       '0);
`endif
        acc = rst && in_valid && !BlockPipe && !e.st;
        if (acc && RegWrite) begin
            if (Vectorop) begin
                for (int k = 0; k < NB; k++) begin
                    if (cyc + 1 + k < MAXC) begin
                        sched[cyc+1+k].vw = 1'b1;
                        sched[cyc+1+k].va = Rd;
                        sched[cyc+1+k].vb = 4'(k * LPB);
                        sched[cyc+1+k].vd = VectorResult[k*64 +: 64];
                        sched[cyc+1+k].st = (k < NB - 1);
                    end
                end
            end else if (Rd != 0) begin
                sched[cyc+1].sw = 1'b1;
                sched[cyc+1].sa = Rd;
                sched[cyc+1].sd = MemtoReg ? data_out : Alu_out;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive(input bit v, input bit bp, input bit rw, input bit m2r,
                         input bit vop, input logic [AW-1:0] rd,
                         input logic [DW-1:0] alu, input logic [DW-1:0] dout);
        in_valid  = v;
        BlockPipe = bp;
        RegWrite  = rw;
        MemtoReg  = m2r;
        Vectorop  = vop;
        Rd        = rd;
        Alu_out   = alu;
        data_out  = dout;
    endtask

    task automatic ramp_vector();
        for (int i = 0; i < NL; i++) begin
            VectorResult[i*DW +: DW] = 16'h0100 + 16'(i);
        end
    endtask

    task automatic random_vector();
        for (int i = 0; i < NL; i++) begin
            VectorResult[i*DW +: DW] = 16'($urandom);
        end
    endtask

    initial begin
        bit acc;
        bit got;
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        clear_sched(0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        VectorResult = '0;
        #1 rst = 1'b0;

        // Reset state
        repeat (3) tick(acc);
        rst = 1'b1;
        tick(acc);

        // Scalar from ALU, then from memory, then to R0
        drive(1, 0, 1, 0, 0, 4'd3, 16'h1234, 16'h0000);
        tick(acc);
        drive(1, 0, 1, 1, 0, 4'd5, 16'h0001, 16'hBEEF);
        tick(acc);
        drive(1, 0, 1, 1, 0, 4'd0, 16'h0001, 16'hBEEF);
        tick(acc);
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        repeat (2) tick(acc);

        // Ramp vector into v7
        ramp_vector();
        drive(1, 0, 1, 0, 1, 4'd7, '0, '0);
        tick(acc);
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        repeat (5) tick(acc);

        // Vector followed by a scalar held valid until taken
        random_vector();
        drive(1, 0, 1, 0, 1, 4'd9, '0, '0);
        tick(acc);
        drive(1, 0, 1, 0, 0, 4'd2, 16'hA5A5, 16'h5A5A);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            tick(acc);
            got = acc;
        end
        check_eq("scalar_after_vec_taken", got, 1'b1);
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        repeat (3) tick(acc);

        // BlockPipe holds off capture for three cycles
        drive(1, 1, 1, 0, 0, 4'd6, 16'h0C0C, '0);
        repeat (3) tick(acc);
        BlockPipe = 1'b0;
        tick(acc);
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        repeat (2) tick(acc);

        // Forwarding candidate: scalar into r4
        drive(1, 0, 1, 0, 0, 4'd4, 16'h4444, '0);
        tick(acc);
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        repeat (2) tick(acc);

        // Asynchronous reset in the middle of a burst
        ramp_vector();
        drive(1, 0, 1, 0, 1, 4'd11, '0, '0);
        tick(acc);
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        tick(acc);
        tick(acc);
        rst = 1'b0;
        #1;
        check_eq("rst_async_ctl",
                 {sreg_we, vreg_we, stall_out, fwd_valid, sreg_waddr, vreg_waddr, vreg_lane_base},
                 '0);
        check_eq("rst_async_vdata", vreg_wdata, '0);
        check_eq("rst_async_sdata", {sreg_wdata, fwd_data, fwd_rd}, '0);
        clear_sched(cyc);
        repeat (2) tick(acc);
        rst = 1'b1;
        repeat (4) tick(acc);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 4) != 0, 1'($urandom), $urandom_range(0, 2) == 0,
                  4'($urandom), 16'($urandom), 16'($urandom));
            random_vector();
            tick(acc);
        end
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        repeat (NB + 2) tick(acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
